softmax_norm: RTL and testbench
===============================

Name: softmax_norm

Overview:
- Final normalisation stage of the softmax datapath, sitting directly downstream of the reciprocal ROM.
- Takes the row sum produced by the reduction stage and drives the ROM address with its top 8 bits.
- Captures the returned Q0.16 reciprocal, then streams the row's exp values through a multiply-round-saturate path.
- Emits uint8 Q0.8 probabilities on a valid/ready stream.

Parameters:
- MAX_LEN, 256, maximum row length in elements.
- LEN_W, 9, width of len_in (must hold MAX_LEN).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  pulse; begin a row (accepted only in IDLE)
- sum_in  input  16  row sum of exp values, unsigned Q8.8
- len_in  input  LEN_W  number of elements in the row (0..MAX_LEN)
- recip_addr  output  8  address to reciprocal ROM
- recip_data  input  16  ROM output, Q0.16; valid exactly 1 cycle after recip_addr
- exp_valid  input  1  exp element valid
- exp_data  input  8  exp element, unsigned Q0.8
- exp_ready  output  1  exp element accepted when exp_valid && exp_ready
- out_valid  output  1  probability valid
- out_data  output  8  probability, unsigned Q0.8
- out_ready  input  1  downstream accepts when out_valid && out_ready
- busy  output  1  high in every state except IDLE
- done  output  1  single-cycle pulse when a row completes

Behaviour:
- Reset (rst=1 at a clk edge), effective next cycle:
  - state=IDLE; recip_addr=0, exp_ready=0, out_valid=0, out_data=0, busy=0, done=0.
  - Internal count and reciprocal registers are cleared.
  - Reset mid-row abandons the row: no done pulse, and a pending out_valid is dropped.
- FSM states: IDLE -> LOOKUP -> CAPTURE -> STREAM -> DRAIN -> IDLE.
- IDLE:
  - On start: register recip_addr<=sum_in[15:8], latch len_in, count<=0, go to LOOKUP.
  - If len_in==0: skip everything, pulse done the next cycle, stay IDLE.
  - start while busy is ignored.
- LOOKUP: one cycle; recip_addr is held, ROM samples it.
- CAPTURE: recip_reg<=recip_data, go to STREAM.
  - Start accepted at cycle k -> first exp_ready possible at cycle k+3.
- STREAM:
  - exp_ready = !out_valid || out_ready (1-entry output register, full throughput).
  - On an exp handshake, compute:
    - p = (exp_data * recip_reg + 32768) >> 16, with a 24-bit product plus rounding constant;
    - out_data = p>255 ? 255 : p[7:0];
    - out_valid<=1 on the next edge (latency 1 cycle from accept to out_valid).
  - out_valid clears on an output handshake unless a new element is accepted in the same cycle.
  - A simultaneous accept and output handshake replaces the data with no bubble.
  - count increments per exp handshake; on the handshake with count==len-1, go to DRAIN. exp_ready is 0 outside STREAM.
- DRAIN:
  - Wait for the final output handshake.
  - In that same cycle go to IDLE; done is pulsed in the following cycle, when busy is already 0.
- out_data and out_valid are held stable while out_valid && !out_ready.
- recip_addr holds its last value outside LOOKUP.
- sum_in below 256 gives address 0; the ROM returns 0xFFFF and the output is approximately exp_data (no special casing required).
- Exactly len outputs per row; extra exp_valid beats after the last element are not accepted.

Test Plan:
- Basic row:
  - Stimulus: sum_in=0x0400 (4.0), len=4, exps 255,128,64,0, out_ready=1; recip_data model returns 16384 for addr 4.
  - Required: recip_addr=4 one cycle after start; outputs 64,32,16,0; done pulses once, the cycle after the last output handshake.
- Saturation/rounding:
  - Stimulus: sum_in=0x0080 (addr 0, recip 0xFFFF), len=2, exps 255,1.
  - Required: outputs 255,1; no wrap above 255.
- Backpressure:
  - Stimulus: len=8, out_ready toggling 1,0,0,1 pattern.
  - Required: no loss or duplication; out_data stable while stalled; exp_ready=0 whenever out_valid && !out_ready; 8 outputs in order.
- Zero length and busy start:
  - Stimulus: start with len=0.
  - Required: done the next cycle, no out_valid.
  - Stimulus: start re-asserted mid-row with a different sum_in.
  - Required: ignored, recip_addr unchanged.
- Reset mid-row:
  - Stimulus: assert rst after 3 of 6 outputs while out_valid=1.
  - Required: next cycle out_valid=0, busy=0, exp_ready=0, no done.
  - Required: a following row with len=2 completes correctly.
- Back-to-back rows:
  - Stimulus: start issued the cycle after done.
  - Required: accepted; the second row uses the new reciprocal (addr 2 -> 32768; exp 200 -> 100).

Source files
------------

// File: rtl/softmax_norm.sv
// Softmax normalisation stage: looks up 1/sum in the reciprocal ROM, then scales
// each exp element to a rounded, saturated Q0.8 probability on a valid/ready stream.
//
// state   | meaning
// IDLE    | waiting for start; zero-length rows complete here directly
// LOOKUP  | recip_addr presented, ROM sampling it
// CAPTURE | ROM data valid, latched into recip_reg
// STREAM  | accepting exp elements through the 1-entry output register
// DRAIN   | last element accepted, waiting for its output handshake
module softmax_norm #(
    parameter int MAX_LEN = 256,
    parameter int LEN_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      sum_in,
    input  logic [LEN_W-1:0] len_in,
    output logic [7:0]       recip_addr,
    input  logic [15:0]      recip_data,
    input  logic             exp_valid,
    input  logic [7:0]       exp_data,
    output logic             exp_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_CAPTURE, S_STREAM, S_DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] count;
    logic [15:0]      recip_reg;
    logic             exp_hs, out_hs, last_elem;
    logic [23:0]      prod;
    logic [24:0]      prod_rnd;
    logic [8:0]       prob;
    logic [7:0]       prob_sat;

    assign exp_hs    = exp_valid && exp_ready;
    assign out_hs    = out_valid && out_ready;
    assign last_elem = (count == len_reg - LEN_W'(1));

    // 24-bit product plus half-LSB rounding; one extra bit keeps the carry
    assign prod     = 24'(exp_data) * 24'(recip_reg);
    assign prod_rnd = 25'(prod) + 25'd32768;
    assign prob     = 9'(prod_rnd >> 16);
    assign prob_sat = (prob > 9'd255) ? 8'hFF : prob[7:0];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start && len_in != '0) state_nxt = S_LOOKUP;
            S_LOOKUP:  state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_STREAM;
            S_STREAM:  if (exp_hs && last_elem) state_nxt = S_DRAIN;
            S_DRAIN:   if (out_hs) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        exp_ready = (state == S_STREAM) && (!out_valid || out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            recip_addr <= '0;
            len_reg    <= '0;
            count      <= '0;
            recip_reg  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE && start) begin
                if (len_in == '0) begin
                    done <= 1'b1;
                end else begin
                    recip_addr <= sum_in[15:8];
                    // oversized lengths are clamped to the supported row length
                    len_reg    <= (len_in > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_in;
                    count      <= '0;
                end
            end
            if (state == S_CAPTURE) recip_reg <= recip_data;
            if (exp_hs) begin
                out_data  <= prob_sat;
                out_valid <= 1'b1;
                count     <= count + LEN_W'(1);
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
            if (state == S_DRAIN && out_hs) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_softmax_norm.sv
// Self-checking bench for softmax_norm: directed rows plus randomized rows, checked
// against an arithmetic reference of the probability rule and a cycle-level protocol monitor.
module tb_softmax_norm;
    localparam int LEN_W = 9;

    logic             clk = 1'b0;
    logic             rst, start;
    logic [15:0]      sum_in;
    logic [LEN_W-1:0] len_in;
    logic [7:0]       recip_addr;
    logic [15:0]      recip_data;
    logic             exp_valid;
    logic [7:0]       exp_data;
    logic             exp_ready, out_valid;
    logic [7:0]       out_data;
    logic             out_ready, busy, done;

    int checks = 0;
    int errors = 0;
    int exps[$];

    always #5 clk = ~clk;

    softmax_norm #(.MAX_LEN(256), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .sum_in(sum_in), .len_in(len_in),
        .recip_addr(recip_addr), .recip_data(recip_data),
        .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    // Reciprocal ROM model: 65536/addr in Q0.16, saturated to 0xFFFF for addr 0 and 1
    function automatic logic [15:0] rom_val(input logic [7:0] a);
        if (a <= 8'd1) return 16'hFFFF;
        return 16'(32'd65536 / 32'(a));
    endfunction

    always @(posedge clk) recip_data <= rom_val(recip_addr);

    function automatic int ref_prob(input int e, input int r);
        int p;
        p = (e * r + 32768) / 65536;
        return (p > 255) ? 255 : p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic fill_random(input int n);
        exps.delete();
        for (int i = 0; i < n; i++) exps.push_back(int'($urandom_range(0, 255)));
    endtask

    // One row: drives start, streams exps, monitors the output stream until done.
    // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    // abort_at: assert rst once this many outputs are seen and out_valid is high.
    // dup_at: re-assert start with a different sum once this many outputs are seen.
    task automatic run_row(input logic [15:0] sum, input int len, input int rdy_mode,
                           input int abort_at, input int dup_at);
        int         expq[$];
        int         e_idx = 0;
        int         n_out = 0;
        int         c = 0;
        int         r;
        logic [7:0] addr;
        logic       last_prev = 1'b0;
        logic       stalled = 1'b0;
        logic       dup_done = 1'b0;
        logic [7:0] stall_data = '0;

        addr = sum[15:8];
        r = int'(rom_val(addr));
        for (int i = 0; i < len; i++) expq.push_back(ref_prob(exps[i], r));

        @(negedge clk);
        start = 1'b1; sum_in = sum; len_in = LEN_W'(len);
        exp_valid = 1'b0; out_ready = 1'b1;

        while (1) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (dup_at != 0 && n_out == dup_at && !dup_done) begin
                start = 1'b1; sum_in = ~sum; len_in = LEN_W'(3); dup_done = 1'b1;
            end
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            exp_valid = (c >= 2) && ($urandom_range(0, 3) != 0);
            exp_data  = (e_idx < len) ? 8'(exps[e_idx]) : 8'($urandom);
            #1;

            if (abort_at != 0 && n_out == abort_at && out_valid) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0; exp_valid = 1'b0;
                #1;
                chk("abort_out_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_exp_ready", exp_ready, 0);
                chk("abort_done", done, 0);
                repeat (3) begin
                    @(negedge clk); #1;
                    chk("abort_no_done", done, 0);
                    chk("abort_idle", busy, 0);
                end
                return;
            end

            if (last_prev) begin
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 0);
                chk("done_out_valid", out_valid, 0);
                return;
            end
            chk("done_low", done, 0);
            chk("recip_addr", recip_addr, addr);
            if (c < 3) chk("ready_early", exp_ready, 0);
            if (c == 3) chk("ready_first", exp_ready, 1);
            if (stalled) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, stall_data);
            end
            if (out_valid && !out_ready) chk("ready_stall", exp_ready, 0);
            stalled    = out_valid && !out_ready;
            stall_data = out_data;

            if (out_valid && out_ready) begin
                chk("extra_out", n_out < len, 1);
                if (n_out < len) chk("out_data", out_data, expq[n_out]);
                n_out++;
                if (n_out == len) last_prev = 1'b1;
            end
            if (exp_valid && exp_ready) begin
                chk("extra_accept", e_idx < len, 1);
                e_idx++;
            end
            if (c > 4000) begin
                chk("timeout", c, 4000);
                return;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sum_in = '0; len_in = '0;
        exp_valid = 1'b0; exp_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_exp_ready", exp_ready, 0);
        chk("rst_recip_addr", recip_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        // basic row: 4.0 -> recip 16384 -> 64,32,16,0
        exps = '{255, 128, 64, 0};
        run_row(16'h0400, 4, 0, 0, 0);

        // address 0 gives recip 0xFFFF; output ~ exp without wrapping
        exps = '{255, 1};
        run_row(16'h0080, 2, 0, 0, 0);

        // backpressure pattern
        fill_random(8);
        run_row(16'h0A37, 8, 1, 0, 0);

        // zero-length row
        @(negedge clk);
        start = 1'b1; sum_in = 16'h1234; len_in = '0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_out_valid", out_valid, 0);
        @(negedge clk); #1;
        chk("zero_done_once", done, 0);
        chk("zero_no_out", out_valid, 0);

        // start while busy is ignored
        fill_random(5);
        run_row(16'h0300, 5, 0, 0, 2);

        // reset mid-row, then a clean row
        fill_random(6);
        run_row(16'h0700, 6, 0, 3, 0);
        exps = '{90, 250};
        run_row(16'h0500, 2, 2, 0, 0);

        // back-to-back rows; second uses addr 2 -> 32768, exp 200 -> 100
        exps = '{10, 77, 3};
        run_row(16'h0600, 3, 0, 0, 0);
        exps = '{200};
        run_row(16'h0200, 1, 0, 0, 0);

        // full-length row
        fill_random(256);
        run_row(16'($urandom), 256, 2, 0, 0);

        // randomized rows
        repeat (8) begin
            int n;
            n = int'($urandom_range(1, 12));
            fill_random(n);
            run_row(16'($urandom), n, int'($urandom_range(0, 2)), 0, 0);
        end

        @(negedge clk); #1;
        chk("final_done_low", done, 0);
        chk("final_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
